// File: rtl/pdm_dac_modulator.sv
// Second-order sigma-delta PDM DAC with saturating integrators.
// Define DSM_DITHER_EN to add +/-1 LSB LFSR dither on the loop input.
module pdm_dac_modulator #(
   parameter int DATA_WIDTH = 16,
   parameter int INT_GUARD  = 4,
   parameter int CLK_DIV    = 1
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  enable,
   input  logic                  sample_clk_ce,
   input  logic [DATA_WIDTH-1:0] sample_in,
   output logic                  tick,
   output logic                  dac_out,
   output logic                  clip
);
   localparam int IW = DATA_WIDTH + INT_GUARD;
   localparam int SW = IW + 2;
   localparam int XE = SW - DATA_WIDTH;
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic signed [SW-1:0] FB =
      {{XE{1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [SW-1:0] MAXV = {3'b000, {(IW-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {3'b111, {(IW-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MID =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0]  sample_q, sample_d;
   logic signed [IW-1:0]   i1_q, i1_d, i2_q, i2_d;
   logic [7:0]             div_q, div_d;
   logic                   tick_q, dac_q, clip_q;
   logic                   dac_d, clip_d, tick_int;
   logic signed [SW-1:0]   x_w, f_w, d_w, i1_w, i2_w;
   logic signed [SW-1:0]   sum1, sum2;
   logic                   ovf1, ovf2;

`ifdef DSM_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (tick_int)
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      d_w = '0;
      if (enable)
         d_w = lfsr_q[0] ? SW'(1) : -SW'(1);
   end

   always_ff @(posedge clk) begin
      if (arst) lfsr_q <= 16'hACE1;
      else      lfsr_q <= lfsr_d;
   end
`else
   assign d_w = '0;
`endif

   always_comb begin
      tick_int = (div_q == DIV_LAST);
      div_d    = tick_int ? 8'd0 : div_q + 8'd1;
      sample_d = sample_clk_ce ? sample_in : sample_q;

      // offset-binary to two's complement is an MSB flip
      x_w = '0;
      if (enable)
         x_w = {{XE{~sample_q[DATA_WIDTH-1]}},
                ~sample_q[DATA_WIDTH-1], sample_q[DATA_WIDTH-2:0]};
      f_w  = dac_q ? FB : -FB;
      i1_w = {{2{i1_q[IW-1]}}, i1_q};
      i2_w = {{2{i2_q[IW-1]}}, i2_q};

      sum1 = i1_w + x_w + d_w - f_w;
      sum2 = i2_w + i1_w - f_w;
      ovf1 = (sum1 > MAXV) || (sum1 < MINV);
      ovf2 = (sum2 > MAXV) || (sum2 < MINV);

      i1_d    = i1_q;
      i2_d    = i2_q;
      dac_d   = dac_q;
      clip_d  = clip_q;
      if (tick_int) begin
         i1_d = ovf1 ? (sum1[SW-1] ? MINV[IW-1:0] : MAXV[IW-1:0])
                     : sum1[IW-1:0];
         i2_d = ovf2 ? (sum2[SW-1] ? MINV[IW-1:0] : MAXV[IW-1:0])
                     : sum2[IW-1:0];
         dac_d  = ~i2_d[IW-1];
         clip_d = clip_q | ovf1 | ovf2;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         sample_q <= MID;
         i1_q     <= '0;
         i2_q     <= '0;
         div_q    <= '0;
         tick_q   <= 1'b0;
         dac_q    <= 1'b0;
         clip_q   <= 1'b0;
      end else begin
         sample_q <= sample_d;
         i1_q     <= i1_d;
         i2_q     <= i2_d;
         div_q    <= div_d;
         tick_q   <= tick_int;
         dac_q    <= dac_d;
         clip_q   <= clip_d;
      end
   end

   assign tick    = tick_q;
   assign dac_out = dac_q;
   assign clip    = clip_q;

endmodule

// File: tb/tb_pdm_dac_modulator.sv
// Bench for pdm_dac_modulator: bit-exact loop model scoreboard,
// density vector table and multi-cycle corner sequences.
module tb_pdm_dac_modulator;
   localparam longint IMAX = 524287;
   localparam longint IMIN = -524288;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        enable = 1'b1;
   logic        sample_clk_ce = 1'b0;
   logic [15:0] sample_in = 16'h8000;
   logic        tick, dac_out, clip;
   logic        tick4, dac4, clip4;

   int n_checks = 0;
   int n_errors = 0;

   pdm_dac_modulator #(.DATA_WIDTH(16), .INT_GUARD(4), .CLK_DIV(1)) dut (
      .clk(clk), .arst(arst), .enable(enable),
      .sample_clk_ce(sample_clk_ce), .sample_in(sample_in),
      .tick(tick), .dac_out(dac_out), .clip(clip));

   pdm_dac_modulator #(.DATA_WIDTH(16), .INT_GUARD(4), .CLK_DIV(4)) dut4 (
      .clk(clk), .arst(arst), .enable(enable),
      .sample_clk_ce(sample_clk_ce), .sample_in(sample_in),
      .tick(tick4), .dac_out(dac4), .clip(clip4));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act,
                      input longint lo, input longint hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // reference model of the CLK_DIV=1 loop, pushed at each edge
   typedef struct { bit t; bit d; bit c; } exp_t;
   exp_t   sb_q[$];
   longint m_i1 = 0, m_i2 = 0, m_samp = 32768;
   bit     m_dac = 0, m_tick = 0, m_clip = 0;
   int     sb_prints = 0;

   always @(posedge clk) begin
      longint x, f, s1, s2;
      if (arst) begin
         m_samp = 32768; m_i1 = 0; m_i2 = 0;
         m_dac = 0; m_tick = 0; m_clip = 0;
      end else begin
         x  = enable ? m_samp - 32768 : 0;
         f  = m_dac ? 32768 : -32768;
         s1 = m_i1 + x - f;
         s2 = m_i2 + m_i1 - f;
         if (s1 > IMAX) begin s1 = IMAX; m_clip = 1; end
         if (s1 < IMIN) begin s1 = IMIN; m_clip = 1; end
         if (s2 > IMAX) begin s2 = IMAX; m_clip = 1; end
         if (s2 < IMIN) begin s2 = IMIN; m_clip = 1; end
         m_i1 = s1; m_i2 = s2;
         m_dac = (s2 >= 0);
         m_tick = 1;
         if (sample_clk_ce) m_samp = longint'(sample_in);
      end
      sb_q.push_back('{t: m_tick, d: m_dac, c: m_clip});
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if ({tick, dac_out, clip} !== {e.t, e.d, e.c}) begin
            n_errors++;
            if (sb_prints < 20) begin
               sb_prints++;
               $display("FAIL sb t=%0t: got tick/dac/clip %b%b%b, expected %b%b%b",
                        $time, tick, dac_out, clip, e.t, e.d, e.c);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk); arst = 1'b1; sample_clk_ce = 1'b0;
      @(negedge clk); arst = 1'b0;
   endtask

   task automatic strobe(input logic [15:0] v);
      sample_in = v; sample_clk_ce = 1'b1;
      @(negedge clk); sample_clk_ce = 1'b0;
   endtask

   task automatic count_ones(input int n, output int ones, output int seen);
      ones = 0; seen = 0;
      for (int c = 0; c < 4*n + 16 && seen < n; c++) begin
         @(negedge clk);
         if (tick) begin seen++; ones += int'(dac_out); end
      end
   endtask

   typedef struct {
      string nm; bit rst; bit en; logic [15:0] s;
      int n; int lo; int hi;
   } vec_t;
   vec_t vecs[6];

   initial begin
      int ones, seen, nt, last, badp, badc;
      logic pd;

      vecs[0] = '{"mid",      1, 1, 16'h8000, 1024,  510,  514};
      vecs[1] = '{"c000",     1, 1, 16'hC000, 4096, 3068, 3076};
      vecs[2] = '{"4000",     0, 1, 16'h4000, 4096, 1020, 1028};
      vecs[3] = '{"2000",     1, 1, 16'h2000, 4096,  508,  516};
      vecs[4] = '{"en0_f000", 1, 0, 16'hF000, 1024,  510,  514};
      vecs[5] = '{"ffff",     1, 1, 16'hFFFF, 2048, 2030, 2048};

      repeat (2) @(negedge clk);
      chk("rst_tick", tick, 0, 0);
      chk("rst_dac",  dac_out, 0, 0);
      chk("rst_clip", clip, 0, 0);
      chk("rst_tick4", tick4, 0, 0);
      arst = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         enable = vecs[i].en;
         strobe(vecs[i].s);
         count_ones(vecs[i].n, ones, seen);
         chk({vecs[i].nm, "_ticks"}, seen, vecs[i].n, vecs[i].n);
         chk({vecs[i].nm, "_ones"}, ones, vecs[i].lo, vecs[i].hi);
         if (vecs[i].s != 16'hFFFF)
            chk({vecs[i].nm, "_clip"}, clip, 0, 0);
      end

      // clip sticky after full-scale overload, cleared only by reset
      chk("ffff_clip", clip, 1, 1);
      strobe(16'h8000);
      repeat (300) @(negedge clk);
      chk("clip_sticky", clip, 1, 1);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      chk("clip_cleared", clip, 0, 0);

      // reset mid-stream wins over a simultaneous strobe
      enable = 1'b1;
      strobe(16'hC000);
      repeat (500) @(negedge clk);
      arst = 1'b1; sample_clk_ce = 1'b1; sample_in = 16'hFFFF;
      @(negedge clk);
      arst = 1'b0; sample_clk_ce = 1'b0;
      chk("mrst_tick", tick, 0, 0);
      chk("mrst_dac",  dac_out, 0, 0);
      chk("mrst_clip", clip, 0, 0);
      count_ones(1024, ones, seen);
      chk("mrst_ones", ones, 510, 514);

      // enable rising with 0xF000 latched
      do_reset();
      enable = 1'b0;
      strobe(16'hF000);
      count_ones(64, ones, seen);
      enable = 1'b1;
      count_ones(1024, ones, seen);
      count_ones(1024, ones, seen);
      chk("enrise_ticks", seen, 1024, 1024);
      chk("enrise_ones", ones, 956, 964);

      // CLK_DIV=4 instance: tick spacing and dac change timing
      do_reset();
      strobe(16'hC000);
      nt = 0; last = -1; badp = 0; badc = 0; pd = dac4;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (tick4) begin
            nt++;
            if (last >= 0 && c - last != 4) badp++;
            last = c;
         end
         if (dac4 !== pd && !tick4) badc++;
         pd = dac4;
      end
      chk("div4_ticks", nt, 250, 250);
      chk("div4_period", badp, 0, 0);
      chk("div4_dacchg", badc, 0, 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
